regfile_be_scrub: RTL and testbench

Parametrised successor to the single-cycle datapath register file.
- Generic data width and depth, with a per-byte write enable and an optional hardwired zero register.
- Optional write-to-read bypass.
- A self-clearing scrub engine that initialises storage after reset or on request, replacing simulation-only preloading.
- Sits between decode (read addresses) and writeback (write port) of the single-cycle core.

---
 rtl/regfile_be_scrub.sv | 110 +++++++++++
 tb/tb_regfile_be_scrub.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile_be_scrub.sv
// Two-read/one-write register file with byte-lane writes, optional zero register,
// optional write-to-read bypass and a scrub engine that fills storage with RESET_VAL.
module regfile_be_scrub #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 5,
  parameter int unsigned       DEPTH     = 32,
  parameter bit                ZERO_REG  = 1'b1,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_req,
  output logic                ready,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_take;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction

  assign wr_take = (state == IDLE) && !clear_req && wr_en && in_range(wr_addr)
                   && !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            ready <= 1'b0;
            idx   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
          idx   <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; gating on rst_n drops any write on an edge taken while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[idx[IDX_W-1:0]] <= RESET_VAL;
      end else if (wr_take) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          if (wr_be[k]) mem[wr_addr[IDX_W-1:0]][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!(ZERO_REG && (a == '0))) begin
      if (state == CLEAR) begin
        v = RESET_VAL;
      end else if (in_range(a)) begin
        v = mem[a[IDX_W-1:0]];
        if (BYPASS && wr_take && (wr_addr == a)) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (wr_be[k]) v[8*k +: 8] = wr_data[8*k +: 8];
          end
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    rd_data1 = read_port(rd_addr1);
    rd_data2 = read_port(rd_addr2);
  end

endmodule

// File: tb/tb_regfile_be_scrub.sv
// Directed bench: instance a uses defaults; instance b has DEPTH=20, no zero register,
// no bypass and RESET_VAL=0x0000CAFE. Both see identical stimulus.
module tb_regfile_be_scrub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        ready_a, ready_b;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] RV_B = 32'h0000CAFE;

  always #5 clk = ~clk;

  regfile_be_scrub u_a (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_a),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_a), .rd_data2(rd2_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
  );

  regfile_be_scrub #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(20), .ZERO_REG(1'b0), .BYPASS(1'b0),
    .RESET_VAL(32'h0000CAFE)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_b),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_b), .rd_data2(rd2_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
  );

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
    rd_addr1 = a1; rd_addr2 = a2; #1;
  endtask

  task automatic test_reset;
    logic [31:0] exp_b;
    rst_n = 1'b0; #2;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready_a got %b exp 0", ready_a); end
    checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready_b got %b exp 0", ready_b); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      checks++; if (ready_a !== (i >= 32)) begin errors++; $display("FAIL scrub_ready_a edge %0d got %b exp %b", i, ready_a, i >= 32); end
      checks++; if (ready_b !== (i >= 20)) begin errors++; $display("FAIL scrub_ready_b edge %0d got %b exp %b", i, ready_b, i >= 20); end
      if (i == 5) begin
        set_rd(5'd3, 5'd0);
        checks++; if (rd1_a !== 32'h0) begin errors++; $display("FAIL clear_rd_a got %h exp 00000000", rd1_a); end
        checks++; if (rd2_a !== 32'h0) begin errors++; $display("FAIL clear_zero_a got %h exp 00000000", rd2_a); end
        checks++; if (rd1_b !== RV_B) begin errors++; $display("FAIL clear_rd_b got %h exp %h", rd1_b, RV_B); end
        checks++; if (rd2_b !== RV_B) begin errors++; $display("FAIL clear_addr0_b got %h exp %h", rd2_b, RV_B); end
      end
    end
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      exp_b = (a < 20) ? RV_B : 32'h0;
      checks++; if (rd1_a !== 32'h0) begin errors++; $display("FAIL init_a addr %0d got %h exp 00000000", a, rd1_a); end
      checks++; if (rd1_b !== exp_b) begin errors++; $display("FAIL init_b addr %0d got %h exp %h", a, rd1_b, exp_b); end
    end
  endtask

  task automatic test_byte_write;
    do_write(5'd5, 32'hDEADBEEF, 4'b1111);
    do_write(5'd5, 32'h00001200, 4'b0010);
    do_write(5'd5, 32'h00000000, 4'b0000);
    set_rd(5'd5, 5'd5);
    checks++; if (rd1_a !== 32'hDEAD12EF) begin errors++; $display("FAIL byte_write_a got %h exp DEAD12EF", rd1_a); end
    checks++; if (rd2_a !== 32'hDEAD12EF) begin errors++; $display("FAIL byte_write_a_p2 got %h exp DEAD12EF", rd2_a); end
    checks++; if (rd1_b !== 32'hDEAD12EF) begin errors++; $display("FAIL byte_write_b got %h exp DEAD12EF", rd1_b); end
  endtask

  task automatic test_bypass;
    do_write(5'd7, 32'hAAAAAAAA, 4'b1111);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; wr_be = 4'b0011;
    set_rd(5'd7, 5'd7);
    checks++; if (rd1_a !== 32'hAAAA5678) begin errors++; $display("FAIL bypass_a got %h exp AAAA5678", rd1_a); end
    checks++; if (rd2_a !== 32'hAAAA5678) begin errors++; $display("FAIL bypass_a_p2 got %h exp AAAA5678", rd2_a); end
    checks++; if (rd1_b !== 32'hAAAAAAAA) begin errors++; $display("FAIL nobypass_b got %h exp AAAAAAAA", rd1_b); end
    @(posedge clk); #1;
    wr_en = 1'b0; #1;
    checks++; if (rd1_a !== 32'hAAAA5678) begin errors++; $display("FAIL post_bypass_a got %h exp AAAA5678", rd1_a); end
    checks++; if (rd1_b !== 32'hAAAA5678) begin errors++; $display("FAIL post_write_b got %h exp AAAA5678", rd1_b); end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
    set_rd(5'd0, 5'd0);
    checks++; if (rd1_a !== 32'h0) begin errors++; $display("FAIL zero_bypass_a got %h exp 00000000", rd1_a); end
    checks++; if (rd1_b !== RV_B) begin errors++; $display("FAIL zero_nobypass_b got %h exp %h", rd1_b, RV_B); end
    @(posedge clk); #1;
    wr_en = 1'b0; #1;
    checks++; if (rd1_a !== 32'h0) begin errors++; $display("FAIL zero_reg_a got %h exp 00000000", rd1_a); end
    checks++; if (rd1_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL no_zero_reg_b got %h exp FFFFFFFF", rd1_b); end
  endtask

  task automatic test_range;
    do_write(5'd25, 32'h11111111, 4'b1111);
    set_rd(5'd25, 5'd19);
    checks++; if (rd1_a !== 32'h11111111) begin errors++; $display("FAIL range_a got %h exp 11111111", rd1_a); end
    checks++; if (rd1_b !== 32'h0) begin errors++; $display("FAIL range_b got %h exp 00000000", rd1_b); end
    checks++; if (rd2_b !== RV_B) begin errors++; $display("FAIL range_b_last got %h exp %h", rd2_b, RV_B); end
  endtask

  task automatic test_clear_req;
    @(negedge clk);
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000055; wr_be = 4'b1111;
    @(posedge clk); #1;
    clear_req = 1'b0; wr_en = 1'b0;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL clear_start_a got %b exp 0", ready_a); end
    checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL clear_start_b got %b exp 0", ready_b); end
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      clear_req = (i == 10);
      wr_en = (i == 20); wr_addr = 5'd2; wr_data = 32'h99999999; wr_be = 4'b1111;
      @(posedge clk); #1;
      checks++; if (ready_a !== (i >= 32)) begin errors++; $display("FAIL clear_ready_a edge %0d got %b exp %b", i, ready_a, i >= 32); end
      checks++; if (ready_b !== (i >= 20)) begin errors++; $display("FAIL clear_ready_b edge %0d got %b exp %b", i, ready_b, i >= 20); end
    end
    @(negedge clk);
    clear_req = 1'b0; wr_en = 1'b0;
    set_rd(5'd3, 5'd2);
    checks++; if (rd1_a !== 32'h0) begin errors++; $display("FAIL clear_addr3_a got %h exp 00000000", rd1_a); end
    checks++; if (rd2_a !== 32'h0) begin errors++; $display("FAIL clear_wr_ignored_a got %h exp 00000000", rd2_a); end
    checks++; if (rd1_b !== RV_B) begin errors++; $display("FAIL clear_addr3_b got %h exp %h", rd1_b, RV_B); end
    checks++; if (rd2_b !== RV_B) begin errors++; $display("FAIL clear_wr_ignored_b got %h exp %h", rd2_b, RV_B); end
  endtask

  task automatic test_reset_mid_scrub;
    do_write(5'd9, 32'h12121212, 4'b1111);
    @(negedge clk); clear_req = 1'b1;
    @(posedge clk); #1; clear_req = 1'b0;
    for (int i = 1; i <= 12; i++) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL midrst_ready_a got %b exp 0", ready_a); end
    checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL midrst_ready_b got %b exp 0", ready_b); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      checks++; if (ready_a !== (i >= 32)) begin errors++; $display("FAIL midrst_scrub_a edge %0d got %b exp %b", i, ready_a, i >= 32); end
      checks++; if (ready_b !== (i >= 20)) begin errors++; $display("FAIL midrst_scrub_b edge %0d got %b exp %b", i, ready_b, i >= 20); end
    end
    set_rd(5'd9, 5'd19);
    checks++; if (rd1_a !== 32'h0) begin errors++; $display("FAIL midrst_addr9_a got %h exp 00000000", rd1_a); end
    checks++; if (rd1_b !== RV_B) begin errors++; $display("FAIL midrst_addr9_b got %h exp %h", rd1_b, RV_B); end
    checks++; if (rd2_b !== RV_B) begin errors++; $display("FAIL midrst_addr19_b got %h exp %h", rd2_b, RV_B); end
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    test_reset;
    test_byte_write;
    test_bypass;
    test_zero_reg;
    test_range;
    test_clear_req;
    test_reset_mid_scrub;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
